score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Sequences the game-score path to the HEX displays. Accepts a binary score over a valid/ready
//  handshake and converts it to BCD serially (shift-add-3, one bit per clock). It then time-shares
//  one proc7segdecoder instance across all digits, one digit per clock. All digit patterns are
//  committed to the display outputs in a single cycle. Sits between the score counter and the HEX pins.
// PARAMETERS
//  SCORE_W     10  width of binary score input
//  NUM_DIGITS   3  decimal digits driven; max displayable = 10**NUM_DIGITS-1 (999)
// PORTS
//  clk          in   1               system clock; all state changes on rising edge
//  reset        in   1               synchronous, active-high reset
//  score_valid  in   1               score is presented and held until accepted
//  score        in   SCORE_W         unsigned binary score
//  blank_lz     in   1               1 = blank leading zeros; sampled at accept
//  score_ready  out  1               block is idle and can accept a score
//  update_done  out  1               one-cycle pulse: hex_out/overflow just updated
//  overflow     out  1               last committed score exceeded max and was saturated
//  hex_out      out  7*NUM_DIGITS    active-low segments; digit k (k=0 ones) at [7k+6:7k]
// BEHAVIOUR
//  - Reset values: hex_out all 1s (all segments off), overflow=0, update_done=0, score_ready=1.
//    FSM returns to IDLE.
//  - FSM states: IDLE -> CONVERT -> DECODE -> DONE -> IDLE.
//    IDLE: score_ready=1. On score_valid&&score_ready:
//      capture min(score, MAX) and the overflow flag (score>MAX); capture blank_lz; clear
//      BCD register and counters; go to CONVERT.
//    CONVERT: exactly SCORE_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift
//      left one bit, taking the MSB of the captured score. After the last bit, go to DECODE.
//    DECODE: exactly NUM_DIGITS cycles. Digit index d runs 0..NUM_DIGITS-1. Nibble d drives the
//      shared decoder; the result is written to shadow[d], or 7'h7F if d is a blanked leading
//      zero. After d=NUM_DIGITS-1, go to DONE.
//    DONE: one cycle. On the exiting edge: hex_out<=shadow, overflow<=captured flag,
//      update_done<=1; go to IDLE.
//  - Latency: counted from the accept edge, hex_out changes SCORE_W+NUM_DIGITS+1 edges later
//    (14 at defaults). update_done is high in the same cycle the new hex_out is first visible.
//    score_ready is also high in that cycle, so back-to-back accepts are allowed.
//  - score_ready=0 in CONVERT/DECODE/DONE. score_valid is ignored there; the sender holds its
//    value. hex_out and overflow keep their previous values until commit; no partial updates
//    are visible.
//  - Leading-zero blanking (blank_lz=1): digit k is blanked iff all nibbles k..NUM_DIGITS-1 are
//    zero and k>0. Digit 0 always shows, so a score of 0 displays "0".
//  - Saturation: score>MAX converts MAX (all 9s) and sets overflow.
//  - Decoder mapping for 0..9 (hex): 40,79,24,30,19,12,02,78,00,10. BCD nibbles never exceed 9.
//  - Reset in any state aborts the operation: the in-flight score is discarded and outputs take
//    their reset values on that edge.
//  - update_done is never high for two consecutive cycles.
// STRUCTURE
//  - Shared include score_display_defs.vh: state encodings (2-bit), SEG_BLANK=7'h7F, and
//    max-value/counter-width localparams derived from NUM_DIGITS and SCORE_W.
//  - One natural sub-module: bin2bcd_serial holds the CONVERT datapath (BCD shift register,
//    add-3 correction, bit counter, start/done strobes). The FSM, digit counter, blanking,
//    shadow registers and the single proc7segdecoder instance stay in this module.
// TESTING
//  1. score=123, blank_lz=0 -> after 14 cycles hex_out={79,24,30}, update_done one pulse,
//     overflow=0.
//  2. score=7, blank_lz=1 -> hex_out={7F,7F,78}. score=0, blank_lz=1 -> {7F,7F,40}.
//  3. score=105, blank_lz=1 -> {79,40,12}: an interior zero is not blanked.
//  4. score=1023 -> hex_out={10,10,10}, overflow=1. Next score=5 -> overflow=0.
//  5. Hold score_valid high with score=42 during the whole conversion of 123 -> exactly one
//     accept during the busy period; 123 is committed, then 42 is accepted in the update_done
//     cycle and committed 14 cycles later.
//  6. reset asserted in cycle 5 of CONVERT -> hex_out all 1s, score_ready=1 next cycle, no
//     update_done pulse. A fresh score=9 then gives {40,40,10} when blank_lz=0.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// Shared types and helpers for the score-to-HEX display path: FSM encoding,
// blank segment pattern and the BCD arithmetic helpers.
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DECODE  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Double-dabble correction: a nibble >= 5 would exceed 9 after the shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Score handshake between the score counter (master) and the display controller (slave).
interface score_display_ctrl_if #(
    parameter int SCORE_W = 10
) ();
    logic               score_valid;
    logic [SCORE_W-1:0] score;
    logic               blank_lz;
    logic               score_ready;

    modport master (output score_valid, output score, output blank_lz, input score_ready);
    modport slave  (input score_valid, input score, input blank_lz, output score_ready);
endinterface

// File: rtl/score_display_ctrl_bin2bcd.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock after start.
module bin2bcd_serial
    import score_display_ctrl_pkg::*;
#(
    parameter int SCORE_W    = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [SCORE_W-1:0]      bin_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    done_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);

    logic [SCORE_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, corr_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Next-state: load on start, otherwise correct-then-shift while busy
    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        corr_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            corr_s[4*k +: 4] = add3(bcd_q[4*k +: 4]);
        end
        if (start_i) begin
            sh_d   = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {corr_s[BCD_W-2:0], sh_q[SCORE_W-1]};
            sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = busy_q && (cnt_q == LAST_BIT);
endmodule

// File: rtl/score_display_ctrl_seg.sv
// Active-low seven-segment decoder for one BCD digit; non-decimal codes show blank.
module proc7segdecoder (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    // Digit-to-segment lookup
    always_comb begin
        seg_o = 7'h7F;
        case (bcd_i)
            4'd0:    seg_o = 7'h40;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: accepts a score, converts it to BCD, decodes digits one per
// clock through a shared decoder into shadow registers, then commits all digits at once.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int SCORE_W    = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    score_display_ctrl_if.slave     score_bus,
    output logic                    update_done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);
    localparam int MAX_VAL = pow10(NUM_DIGITS) - 1;
    localparam int HEX_W   = 7 * NUM_DIGITS;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);

    state_e                    state_q, state_d;
    logic [DIG_W-1:0]          dig_q, dig_d;
    logic [HEX_W-1:0]          shadow_q, shadow_d, hex_q, hex_d;
    logic                      ovf_q, ovf_d, cap_ovf_q, cap_ovf_d;
    logic                      blank_q, blank_d, done_q, done_d;
    logic                      start_s, conv_done_s, over_s, acc_zero_s;
    logic [SCORE_W-1:0]        sat_s;
    logic [4*NUM_DIGITS-1:0]   bcd_s;
    logic [3:0]                nib_s;
    logic [6:0]                seg_s;
    logic [NUM_DIGITS-1:0]     hi_zero_s;

    assign over_s = (32'(score_bus.score) > MAX_VAL);
    assign sat_s  = over_s ? SCORE_W'(MAX_VAL) : score_bus.score;

    bin2bcd_serial #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_s),
        .bin_i   (sat_s),
        .bcd_o   (bcd_s),
        .done_o  (conv_done_s)
    );

    proc7segdecoder u_dec (
        .bcd_i (nib_s),
        .seg_o (seg_s)
    );

    // Digit select and "this digit and all above are zero" mask for blanking
    always_comb begin
        nib_s      = 4'd0;
        acc_zero_s = 1'b1;
        hi_zero_s  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_q == DIG_W'(k)) begin
                nib_s = bcd_s[4*k +: 4];
            end else begin
                nib_s = nib_s;
            end
        end
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc_zero_s   = acc_zero_s && (bcd_s[4*k +: 4] == 4'd0);
            hi_zero_s[k] = acc_zero_s;
        end
    end

    // FSM next-state and datapath control
    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        shadow_d  = shadow_q;
        hex_d     = hex_q;
        ovf_d     = ovf_q;
        cap_ovf_d = cap_ovf_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (score_bus.score_valid) begin
                    start_s   = 1'b1;
                    cap_ovf_d = over_s;
                    blank_d   = score_bus.blank_lz;
                    dig_d     = '0;
                    state_d   = ST_CONVERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (conv_done_s) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_DECODE: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (dig_q == DIG_W'(k)) begin
                        if (blank_q && (k > 0) && hi_zero_s[k]) begin
                            shadow_d[7*k +: 7] = SEG_BLANK;
                        end else begin
                            shadow_d[7*k +: 7] = seg_s;
                        end
                    end else begin
                        shadow_d[7*k +: 7] = shadow_q[7*k +: 7];
                    end
                end
                dig_d = dig_q + DIG_W'(1);
                if (dig_q == LAST_DIG) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DONE: begin
                hex_d   = shadow_q;
                ovf_d   = cap_ovf_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dig_q     <= '0;
            shadow_q  <= '1;
            hex_q     <= '1;
            ovf_q     <= 1'b0;
            cap_ovf_q <= 1'b0;
            blank_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            shadow_q  <= shadow_d;
            hex_q     <= hex_d;
            ovf_q     <= ovf_d;
            cap_ovf_q <= cap_ovf_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    assign score_bus.score_ready = (state_q == ST_IDLE);
    assign update_done           = done_q;
    assign overflow              = ovf_q;
    assign hex_out               = hex_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: vector table through a commit scoreboard, plus
// hand-written sequences for held-valid back-to-back accepts and reset abort.
module tb_score_display_ctrl;
    localparam int LAT = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        update_done, overflow;
    logic [20:0] hex_out;

    always #5 clk = ~clk;

    score_display_ctrl_if #(.SCORE_W(10)) bus ();

    score_display_ctrl #(.SCORE_W(10), .NUM_DIGITS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .score_bus   (bus.slave),
        .update_done (update_done),
        .overflow    (overflow),
        .hex_out     (hex_out)
    );

    typedef struct {
        logic [9:0] score;
        logic       blank;
        logic [6:0] d2, d1, d0;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [20:0] hex;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit monitor: every update_done pops one expected result; hex_out must hold otherwise
    logic        ud_prev  = 1'b0;
    logic        rst_prev = 1'b1;
    logic [20:0] hex_prev;
    always @(negedge clk) begin
        exp_t e;
        if (update_done === 1'b1) begin
            check("ud_not_consecutive", {31'd0, ud_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_update", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("hex_out", {11'd0, hex_out}, {11'd0, e.hex});
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end else if (!rst_prev) begin
            check("hex_hold", {11'd0, hex_out}, {11'd0, hex_prev});
        end else begin
            hex_prev = hex_out;
        end
        ud_prev  = (update_done === 1'b1);
        rst_prev = reset;
        hex_prev = hex_out;
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.score_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", {31'd0, bus.score_ready}, 32'd1);
    endtask

    task automatic wait_done(output int lat, output int busy_ready);
        lat = 0;
        busy_ready = 0;
        while (update_done !== 1'b1 && lat < 60) begin
            if (bus.score_ready !== 1'b0) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 60) sb_q.delete();
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.hex = {v.d2, v.d1, v.d0};
        e.ovf = v.ovf;
        return e;
    endfunction

    task automatic send(input vec_t v);
        int lat, br;
        wait_ready();
        bus.score_valid = 1'b1;
        bus.score       = v.score;
        bus.blank_lz    = v.blank;
        sb_q.push_back(mk_exp(v));
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        wait_done(lat, br);
        check("latency", lat, LAT);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, br, pulses;
        vec_t v42, v123, v5, v9;

        vecs[0]  = '{10'd123,  1'b0, 7'h79, 7'h24, 7'h30, 1'b0};
        vecs[1]  = '{10'd7,    1'b1, 7'h7F, 7'h7F, 7'h78, 1'b0};
        vecs[2]  = '{10'd0,    1'b1, 7'h7F, 7'h7F, 7'h40, 1'b0};
        vecs[3]  = '{10'd105,  1'b1, 7'h79, 7'h40, 7'h12, 1'b0};
        vecs[4]  = '{10'd1023, 1'b0, 7'h10, 7'h10, 7'h10, 1'b1};
        vecs[5]  = '{10'd5,    1'b0, 7'h40, 7'h40, 7'h12, 1'b0};
        vecs[6]  = '{10'd999,  1'b1, 7'h10, 7'h10, 7'h10, 1'b0};
        vecs[7]  = '{10'd1000, 1'b1, 7'h10, 7'h10, 7'h10, 1'b1};
        vecs[8]  = '{10'd80,   1'b1, 7'h7F, 7'h00, 7'h40, 1'b0};
        vecs[9]  = '{10'd0,    1'b0, 7'h40, 7'h40, 7'h40, 1'b0};
        vecs[10] = '{10'd456,  1'b0, 7'h19, 7'h12, 7'h02, 1'b0};
        vecs[11] = '{10'd10,   1'b1, 7'h7F, 7'h79, 7'h40, 1'b0};
        v123 = '{10'd123, 1'b0, 7'h79, 7'h24, 7'h30, 1'b0};
        v42  = '{10'd42,  1'b0, 7'h40, 7'h19, 7'h24, 1'b0};
        v5   = '{10'd5,   1'b1, 7'h7F, 7'h7F, 7'h12, 1'b0};
        v9   = '{10'd9,   1'b0, 7'h40, 7'h40, 7'h10, 1'b0};

        reset           = 1'b1;
        bus.score_valid = 1'b0;
        bus.score       = '0;
        bus.blank_lz    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_hex", {11'd0, hex_out}, 32'h1FFFFF);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_ud", {31'd0, update_done}, 32'd0);
        check("rst_ready", {31'd0, bus.score_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i]);
        end

        // Valid held through the whole busy period: one accept, then the held 42 in the done cycle
        wait_ready();
        bus.score_valid = 1'b1;
        bus.score       = v123.score;
        bus.blank_lz    = v123.blank;
        sb_q.push_back(mk_exp(v123));
        @(posedge clk); #1;
        bus.score = v42.score;
        sb_q.push_back(mk_exp(v42));
        wait_done(lat, br);
        check("held_latency1", lat, LAT);
        check("held_busy_ready", br, 0);
        check("held_ready_in_done", {31'd0, bus.score_ready}, 32'd1);
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        wait_done(lat, br);
        check("held_latency2", lat, LAT);

        // Reset in cycle 5 of CONVERT, with overflow=1 showing beforehand
        send(vecs[4]);
        wait_ready();
        bus.score_valid = 1'b1;
        bus.score       = v5.score;
        bus.blank_lz    = v5.blank;
        sb_q.push_back(mk_exp(v5));
        @(posedge clk); #1;
        bus.score_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        check("abort_hex", {11'd0, hex_out}, 32'h1FFFFF);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        check("abort_ready", {31'd0, bus.score_ready}, 32'd1);
        pulses = 0;
        repeat (20) begin
            if (update_done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        check("abort_no_update", pulses, 0);
        send(v9);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
